// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle: address phase (req..wdata / addr_ok) and
// response phase (data_ok / rdata). The master drives the request side.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master arbiter for one SRAM-like memory port. The winner of each
// address phase is recorded in an in-order ID FIFO so that responses are
// steered back to the instruction (ID 0) or data (ID 1) master in request order.
module sram_like_arbiter #(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned DATA_PRIO = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_like_arbiter_if.slave    inst,
    sram_like_arbiter_if.slave    data,
    sram_like_arbiter_if.master   mem,
    output logic                  rsp_err
);

    localparam int unsigned AW      = $clog2(MAX_OUTST);
    localparam logic [AW:0] MAX_CNT = (AW + 1)'(MAX_OUTST);

    logic          sel;
    logic          sel_req;
    logic          lock;
    logic          lock_sel;
    logic          push;
    logic          pop;
    logic          head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   occ;
    logic          id_fifo [MAX_OUTST];

    // Grant: a stalled address phase keeps its owner, otherwise fixed priority.
    always_comb begin
        sel = 1'b0;
        if (lock)
            sel = lock_sel;
        else if (inst.req && data.req)
            sel = (DATA_PRIO != 0);
        else
            sel = data.req;
    end

    // Address-phase forwarding from the granted master; the full check uses
    // registered occupancy so a same-cycle pop does not release a new request.
    always_comb begin
        sel_req   = sel ? data.req : inst.req;
        mem.req   = sel_req && (occ < MAX_CNT);
        mem.wr    = sel ? data.wr    : inst.wr;
        mem.size  = sel ? data.size  : inst.size;
        mem.wstrb = sel ? data.wstrb : inst.wstrb;
        mem.addr  = sel ? data.addr  : inst.addr;
        mem.wdata = sel ? data.wdata : inst.wdata;
    end

    // Handshake decode and response steering by the oldest outstanding ID.
    always_comb begin
        push         = mem.req && mem.addr_ok;
        pop          = mem.data_ok && (occ != '0);
        head         = id_fifo[rd_ptr];
        inst.addr_ok = push && !sel;
        data.addr_ok = push && sel;
        inst.data_ok = pop && !head;
        data.data_ok = pop && head;
        inst.rdata   = mem.rdata;
        data.rdata   = mem.rdata;
    end

    // Lock tracks an offered-but-unaccepted address; it drops on accept or
    // when the locked master withdraws (mem.req falls, nothing is pushed).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock     <= 1'b0;
            lock_sel <= 1'b0;
        end else begin
            lock     <= mem.req && !mem.addr_ok;
            lock_sel <= sel;
        end
    end

    // ID FIFO pointers, occupancy and the sticky unexpected-response flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
            if (mem.data_ok && (occ == '0))
                rsp_err <= 1'b1;
        end
    end

    // ID storage; contents beyond the pointers are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (push)
            id_fifo[wr_ptr] <= sel;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (MAX_OUTST=4, DATA_PRIO=1).
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    logic resetn;
    logic rsp_err;
    int   checks   = 0;
    int   failures = 0;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if mem_bus ();

    sram_like_arbiter #(
        .MAX_OUTST (4),
        .DATA_PRIO (1)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst    (inst_bus),
        .data    (data_bus),
        .mem     (mem_bus),
        .rsp_err (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'h0;
        inst_bus.addr = '0; inst_bus.wdata = '0;
        data_bus.req = 0; data_bus.wr = 0; data_bus.size = 2'd2; data_bus.wstrb = 4'h0;
        data_bus.addr = '0; data_bus.wdata = '0;
        mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_mem_req", 32'(mem_bus.req), 0);
        chk("rst_inst_addr_ok", 32'(inst_bus.addr_ok), 0);
        chk("rst_data_addr_ok", 32'(data_bus.addr_ok), 0);
        chk("rst_inst_data_ok", 32'(inst_bus.data_ok), 0);
        chk("rst_data_data_ok", 32'(data_bus.data_ok), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        resetn = 1'b1;
        tick();

        // 1: single instruction fetch, response two cycles later
        inst_bus.req = 1; inst_bus.addr = 32'h1c00_0000; mem_bus.addr_ok = 1;
        #1;
        chk("t1_mem_req", 32'(mem_bus.req), 1);
        chk("t1_mem_addr", mem_bus.addr, 32'h1c00_0000);
        chk("t1_inst_addr_ok", 32'(inst_bus.addr_ok), 1);
        chk("t1_data_addr_ok", 32'(data_bus.addr_ok), 0);
        tick();
        inst_bus.req = 0; mem_bus.addr_ok = 0;
        tick();
        mem_bus.data_ok = 1; mem_bus.rdata = 32'hdead_beef;
        #1;
        chk("t1_inst_data_ok", 32'(inst_bus.data_ok), 1);
        chk("t1_data_data_ok", 32'(data_bus.data_ok), 0);
        chk("t1_inst_rdata", inst_bus.rdata, 32'hdead_beef);
        chk("t1_data_rdata", data_bus.rdata, 32'hdead_beef);
        tick();
        mem_bus.data_ok = 0;

        // 2: simultaneous requests, data first, responses in grant order
        inst_bus.req = 1; inst_bus.addr = 32'h0000_1000;
        data_bus.req = 1; data_bus.addr = 32'h0000_2000; data_bus.wr = 1;
        data_bus.wstrb = 4'hf; data_bus.wdata = 32'h1234_5678;
        mem_bus.addr_ok = 1;
        #1;
        chk("t2_addr_d", mem_bus.addr, 32'h0000_2000);
        chk("t2_wr_d", 32'(mem_bus.wr), 1);
        chk("t2_wdata_d", mem_bus.wdata, 32'h1234_5678);
        chk("t2_data_addr_ok", 32'(data_bus.addr_ok), 1);
        chk("t2_inst_addr_ok0", 32'(inst_bus.addr_ok), 0);
        tick();
        data_bus.req = 0; data_bus.wr = 0; data_bus.wstrb = 4'h0;
        #1;
        chk("t2_addr_i", mem_bus.addr, 32'h0000_1000);
        chk("t2_inst_addr_ok", 32'(inst_bus.addr_ok), 1);
        chk("t2_wr_i", 32'(mem_bus.wr), 0);
        tick();
        inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
        #1;
        chk("t2_rsp1_data", 32'(data_bus.data_ok), 1);
        chk("t2_rsp1_inst", 32'(inst_bus.data_ok), 0);
        tick();
        chk("t2_rsp2_inst", 32'(inst_bus.data_ok), 1);
        chk("t2_rsp2_data", 32'(data_bus.data_ok), 0);
        tick();
        mem_bus.data_ok = 0;

        // 3: data stalled three cycles, inst arrives meanwhile
        data_bus.req = 1; data_bus.addr = 32'h0000_3000;
        #1;
        chk("t3_c1_addr", mem_bus.addr, 32'h0000_3000);
        chk("t3_c1_req", 32'(mem_bus.req), 1);
        tick();
        inst_bus.req = 1; inst_bus.addr = 32'h0000_4000;
        #1;
        chk("t3_c2_addr", mem_bus.addr, 32'h0000_3000);
        chk("t3_c2_inst_addr_ok", 32'(inst_bus.addr_ok), 0);
        tick();
        chk("t3_c3_addr", mem_bus.addr, 32'h0000_3000);
        tick();
        mem_bus.addr_ok = 1;
        #1;
        chk("t3_acc_addr", mem_bus.addr, 32'h0000_3000);
        chk("t3_acc_data_addr_ok", 32'(data_bus.addr_ok), 1);
        tick();
        data_bus.req = 0;
        #1;
        chk("t3_sw_addr", mem_bus.addr, 32'h0000_4000);
        chk("t3_sw_inst_addr_ok", 32'(inst_bus.addr_ok), 1);
        tick();
        inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
        #1;
        chk("t3_rsp1_data", 32'(data_bus.data_ok), 1);
        tick();
        chk("t3_rsp2_inst", 32'(inst_bus.data_ok), 1);
        tick();
        mem_bus.data_ok = 0;

        // 3b: lock holds a stalled inst against the higher-priority data master,
        // and is released when inst withdraws
        inst_bus.req = 1; inst_bus.addr = 32'h0000_5000;
        tick();
        data_bus.req = 1; data_bus.addr = 32'h0000_6000;
        #1;
        chk("t3b_lock_addr", mem_bus.addr, 32'h0000_5000);
        tick();
        inst_bus.req = 0;
        #1;
        chk("t3b_withdraw_req", 32'(mem_bus.req), 0);
        tick();
        chk("t3b_release_req", 32'(mem_bus.req), 1);
        chk("t3b_release_addr", mem_bus.addr, 32'h0000_6000);
        data_bus.req = 0;
        tick();

        // 4: fill to MAX_OUTST, then pop frees a slot one cycle later
        inst_bus.req = 1; mem_bus.addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_bus.addr = 32'h100 + 32'(i);
            #1;
            chk("t4_fill_addr_ok", 32'(inst_bus.addr_ok), 1);
            tick();
        end
        inst_bus.addr = 32'h200;
        #1;
        chk("t4_full_mem_req", 32'(mem_bus.req), 0);
        chk("t4_full_addr_ok", 32'(inst_bus.addr_ok), 0);
        mem_bus.data_ok = 1;
        #1;
        chk("t4_pop_inst_data_ok", 32'(inst_bus.data_ok), 1);
        chk("t4_pop_same_cycle_req", 32'(mem_bus.req), 0);
        tick();
        mem_bus.data_ok = 0;
        #1;
        chk("t4_after_pop_req", 32'(mem_bus.req), 1);
        chk("t4_after_pop_addr_ok", 32'(inst_bus.addr_ok), 1);
        tick();
        inst_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_drain_inst", 32'(inst_bus.data_ok), 1);
            tick();
        end
        mem_bus.data_ok = 0;
        #1;
        chk("t4_empty_req", 32'(mem_bus.req), 0);

        // 5: I,D,I,D interleave over three rounds (pointers wrap)
        for (int r = 0; r < 3; r++) begin
            mem_bus.addr_ok = 1;
            for (int k = 0; k < 4; k++) begin
                inst_bus.req = (k % 2 == 0);
                data_bus.req = (k % 2 == 1);
                inst_bus.addr = 32'h7000 + 32'(k);
                data_bus.addr = 32'h8000 + 32'(k);
                #1;
                chk("t5_addr_ok", {30'd0, data_bus.addr_ok, inst_bus.addr_ok},
                    (k % 2 == 0) ? 32'd1 : 32'd2);
                tick();
            end
            inst_bus.req = 0; data_bus.req = 0; mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("t5_route", {30'd0, data_bus.data_ok, inst_bus.data_ok},
                    (k % 2 == 0) ? 32'd1 : 32'd2);
                tick();
            end
            mem_bus.data_ok = 0;
        end

        // 6: unexpected response with empty FIFO
        mem_bus.data_ok = 1;
        #1;
        chk("t6_inst_data_ok", 32'(inst_bus.data_ok), 0);
        chk("t6_data_data_ok", 32'(data_bus.data_ok), 0);
        chk("t6_err_before", 32'(rsp_err), 0);
        tick();
        mem_bus.data_ok = 0;
        chk("t6_err_set", 32'(rsp_err), 1);
        tick();
        chk("t6_err_sticky", 32'(rsp_err), 1);
        resetn = 0;
        tick();
        chk("t6_err_cleared", 32'(rsp_err), 0);
        resetn = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
